// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states and
// the divide-by-zero quotient value.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared mult/div datapath: a shift-add step for multiply
// or one restoring trial-subtract step for divide, on a {upper, lower} work word.
module muldiv_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      is_div,
   input  logic [2*DATA_WIDTH-1:0]   work_in,
   input  logic [DATA_WIDTH-1:0]     operand,
   output logic [2*DATA_WIDTH-1:0]   work_out
);
   localparam int W = DATA_WIDTH;

   logic [W:0]   mul_sum;
   logic [W:0]   shifted;
   logic         fits;
   logic [W-1:0] rem_sub;

   always_comb begin
      // Multiply: upper half accumulates, lower half shifts multiplier bits out.
      mul_sum  = {1'b0, work_in[2*W-1:W]} + (work_in[0] ? {1'b0, operand} : '0);
      // Divide: upper half is the partial remainder, lower half the dividend/quotient.
      shifted  = {work_in[2*W-1:W], work_in[W-1]};
      fits     = (shifted >= {1'b0, operand});
      rem_sub  = shifted[W-1:0] - operand;
      if (is_div) begin
         work_out = {(fits ? rem_sub : shifted[W-1:0]), work_in[W-2:0], fits};
      end else begin
         work_out = {mul_sum, work_in[W-1:1]};
      end
   end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Architectural HI/LO registers with iterative MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO.
// Optional zero-operand shortcut enabled by defining MULDIV_EARLY_OUT_EN.
module hilo_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] HI_reg,
   output logic [DATA_WIDTH-1:0] LO_reg
);
   localparam int W     = DATA_WIDTH;
   localparam int STEPS = W / BITS_PER_CYCLE;

   state_e            state_reg, state_next;
   op_e               op_sel;
   logic              accept_calc;
   logic              zero_operand;
   logic              last_step;

   logic [2*W-1:0]    work_reg;
   logic [W-1:0]      operand_reg;
   logic [W-1:0]      a_raw_reg;
   logic [5:0]        cnt_reg;
   logic              fix_phase_reg;
   logic              is_div_reg;
   logic              neg_res_reg;
   logic              neg_rem_reg;
   logic              a_zero_reg;
   logic              b_zero_reg;
   logic              done_reg;

   logic              a_signed_neg, b_signed_neg, op_signed;
   logic [W-1:0]      a_mag, b_mag;
   logic [2*W-1:0]    fixed_result;
   logic [2*W-1:0]    prod;
   logic [2*W-1:0]    chain [0:BITS_PER_CYCLE];

   assign op_sel       = op_e'(op);
   assign accept_calc  = start && (op[2] == 1'b0);
   assign zero_operand = (op_a == '0) || (op_b == '0);
   assign last_step    = (cnt_reg == 6'(STEPS - 1));
   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;

   assign op_signed    = (op_sel == OP_MULT) || (op_sel == OP_DIV);
   assign a_signed_neg = op_signed && op_a[W-1];
   assign b_signed_neg = op_signed && op_b[W-1];
   assign a_mag        = a_signed_neg ? (~op_a + 1'b1) : op_a;
   assign b_mag        = b_signed_neg ? (~op_b + 1'b1) : op_b;

   assign chain[0] = work_reg;
   generate
      for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
         muldiv_step #(.DATA_WIDTH(W)) u_step (
            .is_div   (is_div_reg),
            .work_in  (chain[gi]),
            .operand  (operand_reg),
            .work_out (chain[gi+1])
         );
      end
   endgenerate

   // Sign correction and the zero-operand overrides, applied in the first FIX cycle.
   always_comb begin
      prod         = a_zero_reg || b_zero_reg ? '0 : work_reg;
      fixed_result = neg_res_reg ? (~prod + 1'b1) : prod;
      if (is_div_reg) begin
         if (b_zero_reg) begin
            fixed_result = {a_raw_reg, DIV_BY_ZERO_LO};
         end else if (a_zero_reg) begin
            fixed_result = '0;
         end else begin
            fixed_result[W-1:0]   = neg_res_reg ? (~work_reg[W-1:0] + 1'b1) : work_reg[W-1:0];
            fixed_result[2*W-1:W] = neg_rem_reg ? (~work_reg[2*W-1:W] + 1'b1) : work_reg[2*W-1:W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept_calc) begin
`ifdef MULDIV_EARLY_OUT_EN
               state_next = zero_operand ? FIX : CALC;
`else
               state_next = CALC;
`endif
            end
         end
         CALC:    if (last_step) state_next = FIX;
         FIX:     if (fix_phase_reg) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         HI_reg        <= '0;
         LO_reg        <= '0;
         done_reg      <= 1'b0;
         work_reg      <= '0;
         operand_reg   <= '0;
         a_raw_reg     <= '0;
         cnt_reg       <= '0;
         fix_phase_reg <= 1'b0;
         is_div_reg    <= 1'b0;
         neg_res_reg   <= 1'b0;
         neg_rem_reg   <= 1'b0;
         a_zero_reg    <= 1'b0;
         b_zero_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept_calc) begin
                  is_div_reg    <= op[1];
                  neg_res_reg   <= a_signed_neg ^ b_signed_neg;
                  neg_rem_reg   <= a_signed_neg;
                  a_zero_reg    <= zero_operand && (op_a == '0);
                  b_zero_reg    <= (op_b == '0);
                  a_raw_reg     <= op_a;
                  cnt_reg       <= '0;
                  fix_phase_reg <= 1'b0;
                  // Divide iterates on the dividend; multiply shifts the multiplier out.
                  work_reg      <= op[1] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                  operand_reg   <= op[1] ? b_mag : a_mag;
               end else if (start && op_sel == OP_MTHI) begin
                  HI_reg <= op_a;
               end else if (start && op_sel == OP_MTLO) begin
                  LO_reg <= op_a;
               end
            end
            CALC: begin
               work_reg <= chain[BITS_PER_CYCLE];
               cnt_reg  <= cnt_reg + 6'd1;
            end
            FIX: begin
               if (!fix_phase_reg) begin
                  work_reg      <= fixed_result;
                  fix_phase_reg <= 1'b1;
               end else begin
                  HI_reg   <= work_reg[2*W-1:W];
                  LO_reg   <= work_reg[W-1:0];
                  done_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed scoreboard bench for hilo_muldiv_unit: expected HI/LO/latency are queued
// at issue and compared when done pulses.
module tb_hilo_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, done;
   logic [31:0] HI_reg, LO_reg;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 34;
`endif
   localparam int LAT = 34;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   failures = 0;

   hilo_muldiv_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .HI_reg (HI_reg),
      .LO_reg (LO_reg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [31:0] hi, input logic [31:0] lo,
                        input int lat);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op = o; op_a = a; op_b = b;
      e.tag = tag; e.hi = hi; e.lo = lo; e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // inject_edge >= 0 attempts an MTLO while the op is in flight.
   task automatic wait_result(input int inject_edge, input logic [31:0] inject_val);
      exp_t        e;
      int          edges = 0;
      int          busy_cnt = 0;
      bit          got = 0;
      logic [31:0] lo_before = LO_reg;
      logic [31:0] hi_before = HI_reg;
      while (edges < 200 && !got) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (start) begin
            start = 1'b0;
            check("mtlo_while_busy", LO_reg, lo_before);
         end
         if (done) begin
            got = 1;
         end else begin
            if (busy) busy_cnt++;
            if (edges == 5) check("hi_hold_during_busy", HI_reg, hi_before);
            if (edges == inject_edge) begin
               start = 1'b1; op = 3'd5; op_a = inject_val;
            end
         end
      end
      e = sb.pop_front();
      $display("[TB] %s: edges=%0d HI=%h LO=%h busy_cycles=%0d", e.tag, edges, HI_reg, LO_reg, busy_cnt);
      check({e.tag, "_latency"}, 32'(edges), 32'(e.lat));
      check({e.tag, "_hi"}, HI_reg, e.hi);
      check({e.tag, "_lo"}, LO_reg, e.lo);
      check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat - 1));
      check({e.tag, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int done_seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_hi", HI_reg, 32'h0);
      check("reset_lo", LO_reg, 32'h0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);

      issue(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT);
      wait_result(-1, '0);
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, LAT);
      wait_result(-1, '0);
      issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT);
      wait_result(-1, '0);
      issue(3'd3, 32'd100, 32'd7, "divu_100_7", 32'h0000_0002, 32'h0000_000E, LAT);
      wait_result(-1, '0);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'h0, 32'h8000_0000, LAT);
      wait_result(-1, '0);
      issue(3'd3, 32'h0000_1234, 32'h0, "divu_by0", 32'h0000_1234, 32'hFFFF_FFFF, ZLAT);
      wait_result(-1, '0);
      issue(3'd2, 32'hFFFF_FFFB, 32'h0, "div_neg_by0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, ZLAT);
      wait_result(-1, '0);
      issue(3'd0, 32'h0, 32'h0001_2345, "mult_zero", 32'h0, 32'h0, ZLAT);
      wait_result(-1, '0);
      issue(3'd2, 32'd20, 32'hFFFF_FFFA, "div_20_m6", 32'h0000_0002, 32'hFFFF_FFFD, LAT);
      wait_result(-1, '0);

      // MTHI in idle: single-cycle, no done
      @(negedge clk);
      start = 1'b1; op = 3'd4; op_a = 32'hCAFE_BABE;
      @(negedge clk);
      start = 1'b0;
      check("mthi_hi", HI_reg, 32'hCAFE_BABE);
      check("mthi_done", {31'd0, done}, 32'd0);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("mthi_done_late", {31'd0, done}, 32'd0);
      $display("[TB] mthi: HI=%h done=%b busy=%b", HI_reg, done, busy);

      // MTLO while busy is dropped
      issue(3'd1, 32'd7, 32'd9, "multu_7x9_mtlo", 32'h0, 32'd63, LAT);
      wait_result(3, 32'hDEAD_BEEF);

      // Reset in the middle of CALC aborts the op
      issue(3'd0, 32'd7, 32'd9, "mult_aborted", 32'h0, 32'h0, LAT);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      void'(sb.pop_front());
      check("abort_hi", HI_reg, 32'h0);
      check("abort_lo", LO_reg, 32'h0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      $display("[TB] abort: HI=%h LO=%h busy=%b done_pulses=%0d", HI_reg, LO_reg, busy, done_seen);

      issue(3'd1, 32'd7, 32'd9, "multu_after_reset", 32'h0, 32'd63, LAT);
      wait_result(-1, '0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
